register_file_mp: RTL and testbench
===================================

# register_file_mp

Parametrised successor to the core's 2-read/1-write integer register file. It adds a configurable read-port count and a same-cycle write-to-read bypass. It also adds a post-reset clearing sequencer so that every register reads as zero before first use, plus a per-register pending scoreboard for load-use and long-latency hazard detection. It sits between decode (reads, reserve) and writeback (write) in the pipeline.

## Interface
Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers, including x0; must be a power of two and at least 4.
- NREAD, 2, number of read ports, 1..4.

Derived value:
- AW = log2(NREGS), the address width.

Ports:
- clk  in  1  single clock; all state is updated on the rising edge.
- reset  in  1  synchronous, active-high reset.
- read_address  in  NREAD*AW  read addresses, flattened; port i occupies bits [i*AW +: AW].
- read_data  out  NREAD*XLEN  read data, flattened; port i occupies bits [i*XLEN +: XLEN]. Combinational.
- read_pending  out  NREAD  pending bit for the register addressed by each read port. Combinational.
- write_address  in  AW  writeback destination register.
- write_data  in  XLEN  writeback value.
- write_enable  in  1  writeback strobe.
- reserve_enable  in  1  marks reserve_address as pending, meaning a producer is in flight.
- reserve_address  in  AW  register to reserve.
- ready  out  1  high once the clear sequence has completed. Reset value 0.

## Operation
- Register x0:
  - Always reads 0.
  - Writes to x0 are discarded.
  - Reserving x0 is discarded; read_pending is never set for x0.
- The block has two states, CLEAR and RUN.
  - Reset value: state CLEAR, clear index 1, all pending bits 0, ready 0.
  - CLEAR while reset is high: the index is held at 1 and no register is written.
  - CLEAR with reset low: registers[idx] is set to 0 and idx increments. When idx equals NREGS-1, that register is written and the next state is RUN.
  - RUN: the block stays in RUN until reset is asserted again.
- While in CLEAR:
  - read_data is all zeros and read_pending is all zeros.
  - write_enable and reserve_enable are ignored.
  - Upstream stalls while ready is 0.
- Write in RUN: if write_enable is high and write_address is not 0, registers[write_address] is updated with write_data and pending[write_address] is cleared.
- Reserve in RUN: if reserve_enable is high and reserve_address is not 0, pending[reserve_address] is set.
- Simultaneous write and reserve to the same address: the reserve wins, so the pending bit ends the cycle set. This models a new producer issued while the old one retires.
- Read in RUN, evaluated per port:
  - If the address is 0, data is 0.
  - Else if write_enable is high and write_address equals the read address, data is write_data (same-cycle bypass) and read_pending for that port is 0.
  - Else data is the stored value and pending is the stored pending bit.
- The bypass does not consider reserve_enable in the same cycle, so a same-cycle reserve does not affect that cycle's read_pending.
- Asserting reset mid-RUN:
  - Returns the block to CLEAR on the next edge.
  - Zeroes all pending bits at that edge.
  - Discards any write presented in the reset cycle.
  - Re-runs the full clear.

## Timing
- Reads: zero latency, combinational from read_address and the write inputs.
- Writes: visible from storage on the cycle after the edge; visible the same cycle through the bypass.
- Pending: a set or clear takes effect at the edge and is observable in the next cycle.
- Clear duration: ready rises at the edge that completes NREGS-1 clearing cycles, counted after reset is first sampled low. With NREGS=32, ready is high in the 32nd cycle after deassertion.
- No combinational path runs from any input to ready.

## Structure
- Package regfile_pkg holds:
  - the state enum {CLEAR, RUN};
  - a helper function for log2 of NREGS.
- Sub-module regfile_scoreboard holds:
  - an NREGS-bit pending vector;
  - the set/clear logic, with reserve winning on conflict;
  - synchronous clear on reset;
  - NREAD lookup outputs.
- The top level holds the storage array, the clear sequencer, and the bypass multiplexers.

## Test plan
- Reset clear: preload garbage via backdoor, then pulse reset for 3 cycles.
  - ready must stay 0 for exactly 31 cycles after deassertion (NREGS=32).
  - After that, reads of x1..x31 must all return 0.
- x0 rules: write 0xDEADBEEF to x0 and reserve x0.
  - Reading x0 must return 0 with pending 0.
- Bypass: write x5=0x12345678 while read port 1 addresses x5.
  - read_data port 1 must be 0x12345678 in the same cycle with pending 0.
  - The next cycle, with no write, it must still be 0x12345678.
- Scoreboard: reserve x7, then in the following cycle read x7.
  - pending must be 1.
  - After a write to x7, pending must be 0.
  - A simultaneous write and reserve of x7 must leave pending at 1.
- Mid-run reset: with x3=0xA5A5A5A5 and x4 pending, assert reset for 1 cycle together with a write to x9.
  - ready must drop and pending must be 0.
  - After the clear completes, x3 and x9 must read 0.
- Parameter sweep: run NREGS=16 with NREAD=4 and XLEN=64.
  - ready must rise after 15 cycles.
  - All 4 ports must return independent values correctly.

Source files
------------

// File: rtl/register_file_mp_pkg.sv
// Shared types and helpers for the multi-port register file and its scoreboard.
package regfile_pkg;

  typedef enum logic [0:0] {CLEAR = 1'b0, RUN = 1'b1} state_e;

  function automatic int regfile_clog2(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/register_file_mp_if.sv
// Decode/writeback-facing bundle of the register file: read ports, writeback, reserve, ready.
interface register_file_mp_if
  import regfile_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2
);
  localparam int AW = regfile_clog2(NREGS);

  logic [NREAD*AW-1:0]   read_address;
  logic [NREAD*XLEN-1:0] read_data;
  logic [NREAD-1:0]      read_pending;
  logic [AW-1:0]         write_address;
  logic [XLEN-1:0]       write_data;
  logic                  write_enable;
  logic                  reserve_enable;
  logic [AW-1:0]         reserve_address;
  logic                  ready;

  modport master (
    output read_address, write_address, write_data, write_enable,
           reserve_enable, reserve_address,
    input  read_data, read_pending, ready
  );

  modport slave (
    input  read_address, write_address, write_data, write_enable,
           reserve_enable, reserve_address,
    output read_data, read_pending, ready
  );

endinterface

// File: rtl/register_file_mp_scoreboard.sv
// Per-register pending bits: set by reserve, cleared by writeback, reserve wins on conflict.
module regfile_scoreboard #(
  parameter int NREGS = 32,
  parameter int NREAD = 2,
  parameter int AW    = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                write_enable,
  input  logic [AW-1:0]       write_address,
  input  logic                reserve_enable,
  input  logic [AW-1:0]       reserve_address,
  input  logic [NREAD*AW-1:0] lookup_address,
  output logic [NREAD-1:0]    lookup_pending
);

  logic [NREGS-1:0]         pending_r;
  logic [NREAD-1:0][AW-1:0] lookup_addr_s;
  logic [NREAD-1:0]         lookup_pending_s;

  assign lookup_addr_s  = lookup_address;
  assign lookup_pending = lookup_pending_s;

  // Pending vector update; the reserve assignment comes last so it overrides a same-address clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_r <= {NREGS{1'b0}};
    end else if (run) begin
      if (write_enable && (write_address != {AW{1'b0}})) begin
        pending_r[write_address] <= 1'b0;
      end
      if (reserve_enable && (reserve_address != {AW{1'b0}})) begin
        pending_r[reserve_address] <= 1'b1;
      end
    end
  end

  // Per-port lookup of the stored pending bit.
  always_comb begin
    lookup_pending_s = {NREAD{1'b0}};
    for (int i = 0; i < NREAD; i++) begin
      lookup_pending_s[i] = pending_r[lookup_addr_s[i]];
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-read-port integer register file with same-cycle write bypass, post-reset clearing
// sequencer and a pending scoreboard for hazard detection.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2
) (
  input logic               clk,
  input logic               reset,
  register_file_mp_if.slave bus
);

  localparam int AW = regfile_clog2(NREGS);
  localparam logic [0:0]    ST_CLEAR = 1'(CLEAR);
  localparam logic [0:0]    ST_RUN   = 1'(RUN);
  localparam logic [AW-1:0] IDX_LAST = AW'(NREGS - 1);

  logic [0:0]                 state_r;
  logic [AW-1:0]              idx_r;
  logic                       ready_r;
  logic [XLEN-1:0]            regs_r [NREGS];
  logic                       run_s;
  logic [NREAD-1:0][AW-1:0]   raddr_s;
  logic [NREAD-1:0][XLEN-1:0] rdata_s;
  logic [NREAD-1:0]           rpend_s;
  logic [NREAD-1:0]           sb_pending_s;

  assign run_s             = (state_r == ST_RUN);
  assign raddr_s           = bus.read_address;
  assign bus.read_data     = rdata_s;
  assign bus.read_pending  = rpend_s;
  assign bus.ready         = ready_r;

  // Clear sequencer: walks x1..x(NREGS-1) once after every reset, then parks in RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_CLEAR;
      idx_r   <= AW'(1);
      ready_r <= 1'b0;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          idx_r <= idx_r + AW'(1);
          if (idx_r == IDX_LAST) begin
            state_r <= ST_RUN;
            ready_r <= 1'b1;
          end
        end
        ST_RUN: begin
          ready_r <= 1'b1;
        end
        default: begin
          state_r <= ST_CLEAR;
          idx_r   <= AW'(1);
          ready_r <= 1'b0;
        end
      endcase
    end
  end

  // Storage: zeroed by the sequencer, then written by writeback; x0 is never written.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_r == ST_CLEAR) begin
        regs_r[idx_r] <= {XLEN{1'b0}};
      end else if (bus.write_enable && (bus.write_address != {AW{1'b0}})) begin
        regs_r[bus.write_address] <= bus.write_data;
      end
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NREAD (NREAD),
    .AW    (AW)
  ) u_scoreboard (
    .clk             (clk),
    .reset           (reset),
    .run             (run_s),
    .write_enable    (bus.write_enable),
    .write_address   (bus.write_address),
    .reserve_enable  (bus.reserve_enable),
    .reserve_address (bus.reserve_address),
    .lookup_address  (bus.read_address),
    .lookup_pending  (sb_pending_s)
  );

  // Read muxes; a retiring write forwards its data and hides the stale pending bit.
  always_comb begin
    rdata_s = {(NREAD*XLEN){1'b0}};
    rpend_s = {NREAD{1'b0}};
    for (int i = 0; i < NREAD; i++) begin
      if (!run_s) begin
        rdata_s[i] = {XLEN{1'b0}};
        rpend_s[i] = 1'b0;
      end else if (raddr_s[i] == {AW{1'b0}}) begin
        rdata_s[i] = {XLEN{1'b0}};
        rpend_s[i] = 1'b0;
      end else if (bus.write_enable && (bus.write_address == raddr_s[i])) begin
        rdata_s[i] = bus.write_data;
        rpend_s[i] = 1'b0;
      end else begin
        rdata_s[i] = regs_r[raddr_s[i]];
        rpend_s[i] = sb_pending_s[i];
      end
    end
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: default 32x32/2-port instance plus a 16x64/4-port instance.
module tb_register_file_mp;

  logic clk = 1'b0;
  logic reset_a = 1'b1;
  logic reset_b = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  register_file_mp_if #(.XLEN(32), .NREGS(32), .NREAD(2)) bus_a ();
  register_file_mp_if #(.XLEN(64), .NREGS(16), .NREAD(4)) bus_b ();

  register_file_mp #(.XLEN(32), .NREGS(32), .NREAD(2)) dut_a (
    .clk   (clk),
    .reset (reset_a),
    .bus   (bus_a)
  );

  register_file_mp #(.XLEN(64), .NREGS(16), .NREAD(4)) dut_b (
    .clk   (clk),
    .reset (reset_b),
    .bus   (bus_b)
  );

  task automatic idle_a();
    bus_a.write_enable    = 1'b0;
    bus_a.write_address   = 5'd0;
    bus_a.write_data      = 32'd0;
    bus_a.reserve_enable  = 1'b0;
    bus_a.reserve_address = 5'd0;
  endtask

  // Counts negedge samples with ready low, starting from the cycle reset was dropped.
  task automatic count_clear_a(output int n);
    n = 0;
    while (bus_a.ready !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    idle_a();
    bus_a.read_address = 10'd0;
    reset_a = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (bus_a.ready !== 1'b0) begin
      bad++; $display("FAIL reset_ready got=%0b exp=0", bus_a.ready);
    end
    reset_a = 1'b0;
    begin
      int n;
      count_clear_a(n);
      total++;
      if (n !== 31) begin
        bad++; $display("FAIL power_up_clear_cycles got=%0d exp=31", n);
      end
    end
  endtask

  task automatic test_garbage_clear();
    for (int r = 1; r < 32; r++) begin
      bus_a.write_enable  = 1'b1;
      bus_a.write_address = 5'(r);
      bus_a.write_data    = 32'hBAD0_0000 | 32'(r);
      @(negedge clk);
    end
    idle_a();
    bus_a.read_address[0 +: 5] = 5'd17;
    #1;
    total++;
    if (bus_a.read_data[0 +: 32] !== 32'hBAD0_0011) begin
      bad++; $display("FAIL garbage_x17 got=%h exp=bad00011", bus_a.read_data[0 +: 32]);
    end
    @(negedge clk);
    reset_a = 1'b1;
    repeat (3) @(negedge clk);
    reset_a = 1'b0;
    begin
      int n;
      count_clear_a(n);
      total++;
      if (n !== 31) begin
        bad++; $display("FAIL reclear_cycles got=%0d exp=31", n);
      end
    end
    for (int r = 1; r < 32; r++) begin
      bus_a.read_address[5 +: 5] = 5'(r);
      #1;
      total++;
      if (bus_a.read_data[32 +: 32] !== 32'd0) begin
        bad++; $display("FAIL cleared_x%0d got=%h exp=0", r, bus_a.read_data[32 +: 32]);
      end
    end
  endtask

  task automatic test_x0();
    @(negedge clk);
    bus_a.write_enable    = 1'b1;
    bus_a.write_address   = 5'd0;
    bus_a.write_data      = 32'hDEAD_BEEF;
    bus_a.reserve_enable  = 1'b1;
    bus_a.reserve_address = 5'd0;
    bus_a.read_address    = {5'd0, 5'd0};
    #1;
    total++;
    if (bus_a.read_data[0 +: 32] !== 32'd0 || bus_a.read_pending[0] !== 1'b0) begin
      bad++; $display("FAIL x0_same_cycle got=%h/%0b exp=0/0", bus_a.read_data[0 +: 32], bus_a.read_pending[0]);
    end
    @(negedge clk);
    idle_a();
    #1;
    total++;
    if (bus_a.read_data[32 +: 32] !== 32'd0 || bus_a.read_pending[1] !== 1'b0) begin
      bad++; $display("FAIL x0_after got=%h/%0b exp=0/0", bus_a.read_data[32 +: 32], bus_a.read_pending[1]);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    bus_a.write_enable  = 1'b1;
    bus_a.write_address = 5'd5;
    bus_a.write_data    = 32'h1234_5678;
    bus_a.read_address  = {5'd5, 5'd6};
    #1;
    total++;
    if (bus_a.read_data[32 +: 32] !== 32'h1234_5678 || bus_a.read_pending[1] !== 1'b0) begin
      bad++; $display("FAIL bypass_same got=%h/%0b exp=12345678/0", bus_a.read_data[32 +: 32], bus_a.read_pending[1]);
    end
    total++;
    if (bus_a.read_data[0 +: 32] !== 32'd0) begin
      bad++; $display("FAIL bypass_other_port got=%h exp=0", bus_a.read_data[0 +: 32]);
    end
    @(negedge clk);
    idle_a();
    #1;
    total++;
    if (bus_a.read_data[32 +: 32] !== 32'h1234_5678) begin
      bad++; $display("FAIL bypass_stored got=%h exp=12345678", bus_a.read_data[32 +: 32]);
    end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    bus_a.reserve_enable  = 1'b1;
    bus_a.reserve_address = 5'd7;
    bus_a.read_address    = {5'd0, 5'd7};
    #1;
    total++;
    if (bus_a.read_pending[0] !== 1'b0) begin
      bad++; $display("FAIL reserve_same_cycle got=%0b exp=0", bus_a.read_pending[0]);
    end
    @(negedge clk);
    idle_a();
    #1;
    total++;
    if (bus_a.read_pending[0] !== 1'b1) begin
      bad++; $display("FAIL reserve_pending got=%0b exp=1", bus_a.read_pending[0]);
    end
    bus_a.write_enable  = 1'b1;
    bus_a.write_address = 5'd7;
    bus_a.write_data    = 32'h0000_0077;
    #1;
    total++;
    if (bus_a.read_pending[0] !== 1'b0 || bus_a.read_data[0 +: 32] !== 32'h77) begin
      bad++; $display("FAIL write_bypass_pend got=%h/%0b exp=77/0", bus_a.read_data[0 +: 32], bus_a.read_pending[0]);
    end
    @(negedge clk);
    idle_a();
    #1;
    total++;
    if (bus_a.read_pending[0] !== 1'b0 || bus_a.read_data[0 +: 32] !== 32'h77) begin
      bad++; $display("FAIL write_clears_pend got=%h/%0b exp=77/0", bus_a.read_data[0 +: 32], bus_a.read_pending[0]);
    end
    bus_a.write_enable    = 1'b1;
    bus_a.write_address   = 5'd7;
    bus_a.write_data      = 32'h0000_0088;
    bus_a.reserve_enable  = 1'b1;
    bus_a.reserve_address = 5'd7;
    @(negedge clk);
    idle_a();
    #1;
    total++;
    if (bus_a.read_pending[0] !== 1'b1 || bus_a.read_data[0 +: 32] !== 32'h88) begin
      bad++; $display("FAIL reserve_wins got=%h/%0b exp=88/1", bus_a.read_data[0 +: 32], bus_a.read_pending[0]);
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    bus_a.write_enable  = 1'b1;
    bus_a.write_address = 5'd3;
    bus_a.write_data    = 32'hA5A5_A5A5;
    @(negedge clk);
    bus_a.write_address   = 5'd9;
    bus_a.write_data      = 32'h0000_0099;
    bus_a.reserve_enable  = 1'b1;
    bus_a.reserve_address = 5'd4;
    @(negedge clk);
    idle_a();
    bus_a.read_address = {5'd3, 5'd4};
    #1;
    total++;
    if (bus_a.read_pending[0] !== 1'b1 || bus_a.read_data[32 +: 32] !== 32'hA5A5_A5A5) begin
      bad++; $display("FAIL pre_reset_state got=%h/%0b exp=a5a5a5a5/1", bus_a.read_data[32 +: 32], bus_a.read_pending[0]);
    end
    @(negedge clk);
    reset_a             = 1'b1;
    bus_a.write_enable  = 1'b1;
    bus_a.write_address = 5'd9;
    bus_a.write_data    = 32'h1212_1212;
    @(negedge clk);
    reset_a = 1'b0;
    idle_a();
    #1;
    total++;
    if (bus_a.ready !== 1'b0 || bus_a.read_pending[0] !== 1'b0) begin
      bad++; $display("FAIL mid_reset_drop got=%0b/%0b exp=0/0", bus_a.ready, bus_a.read_pending[0]);
    end
    begin
      int n;
      count_clear_a(n);
      total++;
      if (n !== 31) begin
        bad++; $display("FAIL mid_reset_clear_cycles got=%0d exp=31", n);
      end
    end
    bus_a.read_address = {5'd9, 5'd4};
    #1;
    total++;
    if (bus_a.read_data[32 +: 32] !== 32'd0 || bus_a.read_pending[0] !== 1'b0) begin
      bad++; $display("FAIL x9_x4_after got=%h/%0b exp=0/0", bus_a.read_data[32 +: 32], bus_a.read_pending[0]);
    end
    bus_a.read_address = {5'd3, 5'd3};
    #1;
    total++;
    if (bus_a.read_data[32 +: 32] !== 32'd0) begin
      bad++; $display("FAIL x3_after got=%h exp=0", bus_a.read_data[32 +: 32]);
    end
  endtask

  task automatic test_sweep();
    logic [63:0] exp_v [4];
    exp_v[0] = 64'h0000_0000_0000_0000;
    exp_v[1] = 64'h1111_2222_3333_4444;
    exp_v[2] = 64'hFEDC_BA98_7654_3210;
    exp_v[3] = 64'hCAFE_F00D_0BAD_BEEF;
    bus_b.write_enable = 1'b0; bus_b.write_address = 4'd0; bus_b.write_data = 64'd0;
    bus_b.reserve_enable = 1'b0; bus_b.reserve_address = 4'd0; bus_b.read_address = 16'd0;
    @(negedge clk);
    reset_b = 1'b0;
    begin
      int n;
      n = 0;
      while (bus_b.ready !== 1'b1 && n < 100) begin
        n++;
        @(negedge clk);
      end
      total++;
      if (n !== 15) begin
        bad++; $display("FAIL sweep_clear_cycles got=%0d exp=15", n);
      end
    end
    bus_b.write_enable = 1'b1;
    bus_b.write_address = 4'd11; bus_b.write_data = exp_v[1]; @(negedge clk);
    bus_b.write_address = 4'd15; bus_b.write_data = exp_v[2]; @(negedge clk);
    bus_b.write_address = 4'd2;  bus_b.write_data = 64'h0123_4567_89AB_CDEF; @(negedge clk);
    // Port 3 catches a same-cycle bypass while ports 1,2 read storage and port 0 reads x0.
    bus_b.write_address = 4'd6;  bus_b.write_data = exp_v[3];
    bus_b.read_address  = {4'd6, 4'd15, 4'd11, 4'd0};
    #1;
    for (int p = 0; p < 4; p++) begin
      total++;
      if (bus_b.read_data[p*64 +: 64] !== exp_v[p]) begin
        bad++; $display("FAIL sweep_port%0d got=%h exp=%h", p, bus_b.read_data[p*64 +: 64], exp_v[p]);
      end
    end
    @(negedge clk);
    bus_b.write_enable = 1'b0;
    bus_b.read_address = {4'd2, 4'd6, 4'd15, 4'd11};
    #1;
    total++;
    if (bus_b.read_data[3*64 +: 64] !== 64'h0123_4567_89AB_CDEF || bus_b.read_data[2*64 +: 64] !== exp_v[3]) begin
      bad++; $display("FAIL sweep_stored got=%h/%h exp=0123456789abcdef/%h",
                      bus_b.read_data[3*64 +: 64], bus_b.read_data[2*64 +: 64], exp_v[3]);
    end
    total++;
    if (bus_b.read_data[0 +: 64] !== exp_v[1] || bus_b.read_data[64 +: 64] !== exp_v[2]) begin
      bad++; $display("FAIL sweep_stored_lo got=%h/%h exp=%h/%h",
                      bus_b.read_data[0 +: 64], bus_b.read_data[64 +: 64], exp_v[1], exp_v[2]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_garbage_clear();
    test_x0();
    test_bypass();
    test_scoreboard();
    test_mid_reset();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
